// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-meter gate controller.
// The escala multiplier helper is only referenced when FREQ_GATE_ESCALA_EN is defined.
package freq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LIMPA    = 3'd1,
    CONTA    = 3'd2,
    ESPERA   = 3'd3,
    REGISTRA = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    X1   = 2'd0,
    X10  = 2'd1,
    X100 = 2'd2
  } escala_t;

  localparam int unsigned MULT_X1   = 1;
  localparam int unsigned MULT_X10  = 10;
  localparam int unsigned MULT_X100 = 100;

  // Code 3 is unused and falls back to the base window.
  function automatic int unsigned escala_mult(input logic [1:0] esc);
    case (esc)
      X10:     return MULT_X10;
      X100:    return MULT_X100;
      default: return MULT_X1;
    endcase
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable down-counter used as the gate-window timer.
// The counter holds at zero, and the zero flag is taken straight from the count.
module gate_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate controller feeding cont_BCD: clear, count gate, result-latch strobe.
// Optional FREQ_GATE_ESCALA_EN adds the escala input, which scales the gate window by 1, 10 or 100.
//
// state    | meaning
// IDLE     | waiting for liga
// LIMPA    | clear pulse to counter, gate timer loaded
// CONTA    | gate open, timer counting down
// ESPERA   | settle time after gate closes
// REGISTRA | result latch strobe, measurement count bumped
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NMED_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              liga,
`ifdef FREQ_GATE_ESCALA_EN
  input  logic [1:0]        escala,
`endif
  output logic              limp,
  output logic              hab,
  output logic              registra,
  output logic              ocupado,
  output logic [2:0]        estado,
  output logic [NMED_W-1:0] n_medidas
);

`ifdef FREQ_GATE_ESCALA_EN
  localparam int unsigned TMR_W = $clog2(100 * GATE_CYCLES + 1);
`else
  localparam int unsigned TMR_W = $clog2(GATE_CYCLES + 1);
`endif
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  estado_t            state_q, state_nx;
  logic               tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]   tmr_load_val;
  logic [SET_W-1:0]   settle_q;

  always_comb begin
`ifdef FREQ_GATE_ESCALA_EN
    tmr_load_val = TMR_W'(GATE_CYCLES * escala_mult(escala) - 1);
`else
    tmr_load_val = TMR_W'(GATE_CYCLES - 1);
`endif
  end

  gate_timer #(.W(TMR_W)) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nx = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (liga) state_nx = LIMPA;
      end
      LIMPA: begin
        tmr_load = 1'b1;
        state_nx = CONTA;
      end
      CONTA: begin
        if (tmr_zero) state_nx = ESPERA;
        else          tmr_dec  = 1'b1;
      end
      ESPERA: begin
        if (settle_q == '0) state_nx = REGISTRA;
      end
      REGISTRA: begin
        state_nx = liga ? LIMPA : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy matches the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      limp      <= 1'b0;
      hab       <= 1'b0;
      registra  <= 1'b0;
      ocupado   <= 1'b0;
      n_medidas <= '0;
    end else begin
      state_q  <= state_nx;
      settle_q <= (state_q == ESPERA) ? settle_q - SET_W'(1) : SET_W'(SETTLE_CYCLES - 1);
      limp     <= (state_nx == LIMPA);
      hab      <= (state_nx == CONTA);
      registra <= (state_nx == REGISTRA);
      ocupado  <= (state_nx != IDLE);
      if (state_nx == REGISTRA) n_medidas <= n_medidas + NMED_W'(1);
    end
  end

  assign estado = state_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl: a measurement-position model checked every cycle plus literal checkpoints.
// The escala scenario is compiled only when FREQ_GATE_ESCALA_EN is defined.
module tb_freq_gate_ctrl;

  localparam int G = 10;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic liga = 1'b0;
  logic [1:0] escala = 2'd0;

  logic       limp8, hab8, reg8, ocu8;
  logic [2:0] est8;
  logic [7:0] n8;
  logic       limp2, hab2, reg2, ocu2;
  logic [2:0] est2;
  logic [1:0] n2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  freq_gate_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .NMED_W(8)) dut8 (
    .clk(clk), .reset(reset), .liga(liga),
`ifdef FREQ_GATE_ESCALA_EN
    .escala(escala),
`endif
    .limp(limp8), .hab(hab8), .registra(reg8), .ocupado(ocu8),
    .estado(est8), .n_medidas(n8)
  );

  freq_gate_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .NMED_W(2)) dut2 (
    .clk(clk), .reset(reset), .liga(liga),
`ifdef FREQ_GATE_ESCALA_EN
    .escala(escala),
`endif
    .limp(limp2), .hab(hab2), .registra(reg2), .ocupado(ocu2),
    .estado(est2), .n_medidas(n2)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a measurement is a run of positions 0 (clear), 1..w (gate), w+1..w+S (settle), w+S+1 (strobe).
  int busy = 0;
  int pos = 0;
  int mw = G;
  int cnt = 0;

  function automatic int mult(input logic [1:0] e);
`ifdef FREQ_GATE_ESCALA_EN
    return (e == 2'd1) ? 10 : (e == 2'd2) ? 100 : 1;
`else
    return 1;
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      busy = 0; pos = 0; cnt = 0;
    end else if (busy == 0) begin
      if (liga) begin busy = 1; pos = 0; end
    end else if (pos == mw + S + 1) begin
      if (liga) pos = 0;
      else busy = 0;
    end else begin
      if (pos == 0) mw = G * mult(escala);
      pos++;
      if (pos == mw + S + 1) cnt++;
    end
  end

  always @(negedge clk) begin
    int e_limp, e_hab, e_reg, e_est;
    e_limp = (busy != 0 && pos == 0) ? 1 : 0;
    e_hab  = (busy != 0 && pos >= 1 && pos <= mw) ? 1 : 0;
    e_reg  = (busy != 0 && pos == mw + S + 1) ? 1 : 0;
    e_est  = (busy == 0) ? 0 : (pos == 0) ? 1 : (pos <= mw) ? 2 : (pos <= mw + S) ? 3 : 4;
    chk("limp", int'(limp8), e_limp);
    chk("hab", int'(hab8), e_hab);
    chk("registra", int'(reg8), e_reg);
    chk("ocupado", int'(ocu8), busy);
    chk("estado", int'(est8), e_est);
    chk("n_medidas8", int'(n8), cnt % 256);
    chk("n_medidas2", int'(n2), cnt % 4);
    chk("estado2", int'(est2), e_est);
    chk("exclusive", ((int'(limp8) + int'(hab8) + int'(reg8)) <= 1) ? 1 : 0, 1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_limp();
    int found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      step();
      if (limp8) found = 1;
    end
    chk("limp_seen", found, 1);
  endtask

  // Counts gate cycles from the next clear pulse up to its strobe; switches escala after change_at steps.
  task automatic run_window(input int change_at, input logic [1:0] new_esc, output int h);
    int done = 0;
    h = 0;
    wait_limp();
    for (int i = 1; i < 1500 && done == 0; i++) begin
      step();
      if (i == change_at) escala = new_esc;
      h += int'(hab8);
      if (reg8) done = 1;
    end
    chk("registra_seen", done, 1);
  endtask

  initial begin
    int t0, h, r;
    int q[$];
    int exp3[5];
    exp3 = '{1, 2, 3, 0, 1};

    // Reset held with liga high
    reset = 1'b1; liga = 1'b1;
    repeat (3) step();
    chk("rst_estado", int'(est8), 0);
    chk("rst_n", int'(n8), 0);
    chk("rst_ocupado", int'(ocu8), 0);
    reset = 1'b0;

    // One full measurement, then the next clear 14 cycles later
    wait_limp();
    t0 = cyc; h = 0; r = 0;
    for (int i = 1; i <= 13; i++) begin
      step();
      h += int'(hab8);
      r += int'(reg8);
      if (reg8) q.push_back(int'(n2));
    end
    step();
    chk("limp_again", int'(limp8), 1);
    chk("period", cyc - t0, 14);
    chk("hab_len", h, 10);
    chk("reg_count", r, 1);
    chk("n_after_1", int'(n8), 1);

    // Narrow counter wrap over four more measurements
    for (int i = 0; i < 56; i++) begin
      step();
      if (reg8) q.push_back(int'(n2));
    end
    chk("wrap_len", q.size(), 5);
    for (int i = 0; i < 5 && i < q.size(); i++) chk("wrap_seq", q[i], exp3[i]);

    // liga dropped during the gate: sequence completes, then idle
    h = 0; r = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      h += int'(hab8);
    end
    liga = 1'b0;
    for (int i = 5; i <= 13; i++) begin
      step();
      h += int'(hab8);
      r += int'(reg8);
    end
    step();
    chk("drop_hab_len", h, 10);
    chk("drop_reg_count", r, 1);
    chk("drop_ocupado", int'(ocu8), 0);
    chk("drop_n", int'(n8), 6);
    repeat (3) step();
    chk("idle_stays", int'(est8), 0);

    // Reset in the middle of the gate
    liga = 1'b1;
    wait_limp();
    repeat (5) step();
    chk("hab5", int'(hab8), 1);
    reset = 1'b1;
    step();
    chk("abort_hab", int'(hab8), 0);
    chk("abort_estado", int'(est8), 0);
    chk("abort_reg", int'(reg8), 0);
    chk("abort_n", int'(n8), 0);
    reset = 1'b0; liga = 1'b0;
    r = 0;
    repeat (20) begin
      step();
      r += int'(reg8);
    end
    chk("no_reg_after_abort", r, 0);

`ifdef FREQ_GATE_ESCALA_EN
    escala = 2'd1; liga = 1'b1;
    run_window(20, 2'd2, h);
    chk("esc_x10", h, 100);
    run_window(500, 2'd3, h);
    chk("esc_x100", h, 1000);
    run_window(0, 2'd3, h);
    chk("esc_code3", h, 10);
    liga = 1'b0;
    repeat (20) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
